// File: rtl/if_fetch_pc_gen.sv
// IF-stage fetch-address generator: walks the fetch PC, reads the prediction table on every
// granted fetch, follows taken/hit predictions and EX redirects, and buffers one instruction for ID.
`timescale 1ns/1ps

module if_fetch_pc_gen #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter bit          PRED_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic        instr_gnt,
    input  logic        instr_rvalid,
    input  logic [31:0] instr_rdata,
    output logic        bht_rd_en,
    output logic [31:0] bht_pc,
    input  logic        bht_predict_taken,
    input  logic        btb_hit,
    input  logic [31:0] btb_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_pred_taken
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] fetch_pc_r;
    logic        kill_r;
    logic        first_wait_r;
    logic        pred_taken_r;
    logic        pred_hit_r;
    logic [31:0] pred_target_r;
    logic [31:0] pend_instr_r;
    logic [31:0] pend_pc_r;
    logic        pend_pred_r;

    logic        grant_s;
    logic        resp_live_s;
    logic        out_free_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic [31:0] next_pc_s;
    logic        load_direct_s;
    logic        load_pend_s;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Datapath decode: consumption of a response and the PC that follows it
    always_comb begin
        grant_s       = (state_r == ST_REQ) && instr_gnt;
        resp_live_s   = (state_r == ST_WAIT) && instr_rvalid && !kill_r && !ex_redirect;
        out_free_s    = !if_valid || id_ready;
        // The prediction arrives one cycle after the grant; an early response must use it live.
        if (first_wait_r) begin
            taken_s  = PRED_EN && bht_predict_taken && btb_hit;
            target_s = align_word(btb_target);
        end else begin
            taken_s  = PRED_EN && pred_taken_r && pred_hit_r;
            target_s = pred_target_r;
        end
        next_pc_s     = taken_s ? target_s : (fetch_pc_r + 32'd4);
        load_direct_s = resp_live_s && out_free_s;
        load_pend_s   = (state_r == ST_STALL) && id_ready && !ex_redirect;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                if (instr_gnt) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!instr_rvalid) begin
                    state_next_s = ST_WAIT;
                end else if (ex_redirect || kill_r || out_free_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            ST_STALL: begin
                if (ex_redirect || id_ready) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // FSM outputs: memory request and the same-cycle prediction-table read
    always_comb begin
        instr_req  = (state_r == ST_REQ);
        instr_addr = fetch_pc_r;
        bht_rd_en  = PRED_EN && grant_s;
        bht_pc     = fetch_pc_r;
    end

    // Fetch PC: redirect wins, otherwise advance when a live response is consumed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= BOOT_ADDR;
        end else if (ex_redirect) begin
            fetch_pc_r <= align_word(ex_redirect_pc);
        end else if (resp_live_s) begin
            fetch_pc_r <= next_pc_s;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Kill marks the outstanding fetch as stale so its response is dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kill_r <= 1'b0;
        end else if ((state_r == ST_WAIT) && instr_rvalid) begin
            kill_r <= 1'b0;
        end else if (ex_redirect && ((state_r == ST_WAIT) || grant_s)) begin
            kill_r <= 1'b1;
        end else begin
            kill_r <= kill_r;
        end
    end

    // Prediction capture in the first WAIT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_wait_r  <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_hit_r    <= 1'b0;
            pred_target_r <= 32'h0000_0000;
        end else begin
            first_wait_r <= grant_s;
            if (first_wait_r) begin
                pred_taken_r  <= bht_predict_taken;
                pred_hit_r    <= btb_hit;
                pred_target_r <= align_word(btb_target);
            end else begin
                pred_taken_r  <= pred_taken_r;
                pred_hit_r    <= pred_hit_r;
                pred_target_r <= pred_target_r;
            end
        end
    end

    // Pending slot holds a response that found the output register occupied
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_instr_r <= 32'h0000_0000;
            pend_pc_r    <= 32'h0000_0000;
            pend_pred_r  <= 1'b0;
        end else if (resp_live_s && !out_free_s) begin
            pend_instr_r <= instr_rdata;
            pend_pc_r    <= fetch_pc_r;
            pend_pred_r  <= taken_s;
        end else begin
            pend_instr_r <= pend_instr_r;
            pend_pc_r    <= pend_pc_r;
            pend_pred_r  <= pend_pred_r;
        end
    end

    // Output register toward ID
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid      <= 1'b0;
            if_instr      <= 32'h0000_0000;
            if_pc         <= 32'h0000_0000;
            if_pred_taken <= 1'b0;
        end else if (ex_redirect) begin
            if_valid <= 1'b0;
        end else if (load_direct_s) begin
            if_valid      <= 1'b1;
            if_instr      <= instr_rdata;
            if_pc         <= fetch_pc_r;
            if_pred_taken <= taken_s;
        end else if (load_pend_s) begin
            if_valid      <= 1'b1;
            if_instr      <= pend_instr_r;
            if_pc         <= pend_pc_r;
            if_pred_taken <= pend_pred_r;
        end else if (id_ready) begin
            if_valid <= 1'b0;
        end else begin
            if_valid <= if_valid;
        end
    end

endmodule

// File: tb/tb_if_fetch_pc_gen.sv
// Bench for if_fetch_pc_gen: directed scenarios pinned with literal addresses, then random traffic
// against a transaction-level model (pending fetch, two-deep delivery queue, next-PC rules).
`timescale 1ns/1ps

module tb_if_fetch_pc_gen;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam bit          PRED = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        bht_rd_en;
    logic [31:0] bht_pc;
    logic        bht_predict_taken;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_pred_taken;

    always #5 clk = ~clk;

    if_fetch_pc_gen #(.BOOT_ADDR(BOOT), .PRED_EN(PRED)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
        .bht_rd_en(bht_rd_en), .bht_pc(bht_pc), .bht_predict_taken(bht_predict_taken),
        .btb_hit(btb_hit), .btb_target(btb_target),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pred_taken(if_pred_taken)
    );

    int checks = 0;
    int errors = 0;

    // Directed-mode knobs
    bit          directed = 1'b1;
    bit          force_rvalid = 1'b0;
    logic        d_bht = 1'b0, d_hit = 1'b0, d_redir = 1'b0, d_ready = 1'b1;
    logic [31:0] d_tgt = 32'h0, d_rpc = 32'h0;
    int          d_delay = 0;

    // Model state
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; logic pred; } ent_t;
    ent_t        q[$];
    bit          m_boot, m_out, m_stale, m_first, m_pt, m_ph;
    logic [31:0] m_pc, m_opc, m_tgt;
    int          m_delay;
    int          n_grants = 0;
    logic [31:0] dut_log[$];
    logic [31:0] mod_log[$];
    logic [31:0] exp_log [12];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_req();
        return !m_boot && !m_out && (q.size() < 2);
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_boot = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_first = 1'b0;
        m_pt = 1'b0; m_ph = 1'b0; m_pc = BOOT; m_opc = 32'h0; m_tgt = 32'h0; m_delay = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        instr_gnt = 1'b1; instr_rvalid = 1'b1; instr_rdata = 32'hDEAD_BEEF;
        bht_predict_taken = 1'b1; btb_hit = 1'b1; btb_target = 32'h0000_1000;
        ex_redirect = 1'b0; ex_redirect_pc = 32'h0; id_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_instr_req", instr_req, 1'b0);
        chk1("rst_bht_rd_en", bht_rd_en, 1'b0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk32("rst_if_instr", if_instr, 32'h0);
        chk32("rst_if_pc", if_pc, 32'h0);
        chk1("rst_if_pred", if_pred_taken, 1'b0);
        reset_n = 1'b1;
        model_reset();
        force_rvalid = 1'b1;
    endtask

    // One cycle: drive inputs, compare outputs against the model, advance the model over the edge
    task automatic step();
        bit req, pop, done, taken;
        logic [31:0] pc0;
        req = m_req();
        pc0 = m_pc;
        if (directed) begin
            instr_gnt = req; bht_predict_taken = d_bht; btb_hit = d_hit; btb_target = d_tgt;
            ex_redirect = d_redir; ex_redirect_pc = d_rpc; id_ready = d_ready;
        end else begin
            instr_gnt = req && ($urandom_range(0, 3) != 0);
            bht_predict_taken = ($urandom_range(0, 1) == 1);
            btb_hit = ($urandom_range(0, 1) == 1);
            btb_target = $urandom;
            ex_redirect = ($urandom_range(0, 19) == 0);
            ex_redirect_pc = $urandom;
            id_ready = ($urandom_range(0, 3) != 0);
        end
        if (m_out) instr_rvalid = (m_delay == 0);
        else       instr_rvalid = force_rvalid || (!directed && ($urandom_range(0, 7) == 0));
        force_rvalid = 1'b0;
        instr_rdata = (m_out && instr_rvalid) ? mem_word(m_opc) : $urandom;
        #1;
        chk1("instr_req", instr_req, req);
        if (req) chk32("instr_addr", instr_addr, pc0);
        chk1("bht_rd_en", bht_rd_en, req && instr_gnt && PRED);
        if (req && instr_gnt) chk32("bht_pc", bht_pc, pc0);
        chk1("if_valid", if_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk32("if_instr", if_instr, q[0].instr);
            chk32("if_pc", if_pc, q[0].pc);
            chk1("if_pred_taken", if_pred_taken, q[0].pred);
        end
        if (req && instr_gnt) begin
            dut_log.push_back(instr_addr);
            mod_log.push_back(pc0);
            n_grants++;
        end
        // Prediction is whatever the table shows the cycle after the grant
        if (m_out && m_first) begin
            m_pt = bht_predict_taken; m_ph = btb_hit; m_tgt = {btb_target[31:2], 2'b00};
        end
        m_first = 1'b0;
        m_boot = 1'b0;
        pop = id_ready && (q.size() > 0);
        done = m_out && instr_rvalid;
        if (m_out && !instr_rvalid) m_delay--;
        if (ex_redirect) begin
            q.delete();
            m_pc = {ex_redirect_pc[31:2], 2'b00};
            if (done) m_out = 1'b0;
            else if (m_out) m_stale = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (done) begin
                m_out = 1'b0;
                if (!m_stale) begin
                    taken = PRED && m_pt && m_ph;
                    q.push_back('{instr: mem_word(m_opc), pc: m_opc, pred: taken});
                    m_pc = taken ? m_tgt : (m_opc + 32'd4);
                end
            end
        end
        if (req && instr_gnt) begin
            m_out = 1'b1; m_stale = ex_redirect; m_opc = pc0; m_first = 1'b1;
            m_delay = directed ? d_delay : int'($urandom_range(0, 3));
        end
    endtask

    task automatic cyc();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fetches(input int n, input string tag);
        int target, cnt;
        target = n_grants + n;
        cnt = 0;
        while ((n_grants < target || m_out) && cnt < 100) begin
            cyc();
            cnt++;
        end
        checks++;
        if (cnt >= 100) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, grants %0d expected %0d", tag, cnt, n_grants, target);
        end
    endtask

    task automatic wait_model(input bit want_out, input string tag);
        int cnt;
        cnt = 0;
        while ((want_out ? !m_out : !m_req()) && cnt < 100) begin
            cyc();
            cnt++;
        end
        checks++;
        if (cnt >= 100) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles", tag, cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_log = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h040,
                    32'h080, 32'h084, 32'h200, 32'h204, 32'h208, 32'h300};
        do_reset();

        // Sequential fetch, no hits, immediate responses
        run_fetches(4, "seq");
        // Taken prediction with a two-cycle response
        d_bht = 1'b1; d_hit = 1'b1; d_tgt = 32'h0000_0040; d_delay = 1;
        run_fetches(1, "pred_slow");
        chk32("pred_if_pc", if_pc, 32'h0000_0010);
        chk1("pred_if_taken", if_pred_taken, 1'b1);
        // Taken prediction consumed through the bypass
        d_tgt = 32'h0000_0083; d_delay = 0;
        run_fetches(1, "pred_bypass");
        // Taken but BTB miss falls through
        d_hit = 1'b0;
        run_fetches(1, "btb_miss");
        chk1("miss_if_taken", if_pred_taken, 1'b0);
        // Redirect while waiting on 0x84
        d_bht = 1'b0; d_delay = 3;
        wait_model(1'b1, "wait_84");
        d_redir = 1'b1; d_rpc = 32'h0000_0203;
        cyc();
        d_redir = 1'b0;
        chk1("redir_if_valid", if_valid, 1'b0);
        d_delay = 0;
        run_fetches(1, "after_redir");
        chk32("redir_if_pc", if_pc, 32'h0000_0200);
        // ID back-pressure forces the STALL path
        d_ready = 1'b0;
        run_fetches(1, "stall_fill");
        for (int i = 0; i < 3; i++) begin
            chk1("stall_no_req", instr_req, 1'b0);
            chk32("stall_if_pc", if_pc, 32'h0000_0200);
            cyc();
        end
        d_ready = 1'b1;
        cyc();
        chk32("unstall_if_pc", if_pc, 32'h0000_0204);
        chk1("unstall_req", instr_req, 1'b1);
        // Redirect coincident with the grant at 0x208
        wait_model(1'b0, "req_208");
        d_redir = 1'b1; d_rpc = 32'h0000_0300;
        cyc();
        d_redir = 1'b0;
        run_fetches(1, "after_gnt_redir");
        chk32("gnt_redir_if_pc", if_pc, 32'h0000_0300);

        chk32("log_len", 32'(dut_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < dut_log.size(); i++) begin
            chk32($sformatf("dut_addr_%0d", i), dut_log[i], exp_log[i]);
            chk32($sformatf("model_addr_%0d", i), mod_log[i], exp_log[i]);
        end

        // Random traffic with a reset in the middle of it
        directed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cyc();
        end
        chk1("random_progress", n_grants > 300, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_pc_gen.md
Name: if_fetch_pc_gen

Overview:
IF-stage fetch-address generator and instruction buffer. It sits directly upstream of the branch history table and the ID stage.
- Issues instruction-memory requests and drives the table read (rd_en/pc_if) for every granted fetch.
- Consumes the 1-cycle-latency taken prediction plus a BTB target to choose the next fetch PC.
- Applies EX-stage redirects and delivers instruction/PC/prediction to ID through a one-entry output register.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch PC after reset; bits [1:0] must be 0.
PRED_EN, 1, 1 = use prediction; 0 = bht_rd_en tied 0 and next PC is always PC+4.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
instr_req  out  1  fetch request
instr_addr  out  32  fetch address, word aligned
instr_gnt  in  1  address phase accepted
instr_rvalid  in  1  response valid
instr_rdata  in  32  response data
bht_rd_en  out  1  prediction-table read strobe
bht_pc  out  32  PC used for the prediction-table read
bht_predict_taken  in  1  prediction, valid the cycle after bht_rd_en
btb_hit  in  1  target-buffer hit, same timing as bht_predict_taken
btb_target  in  32  predicted target, same timing
ex_redirect  in  1  EX misprediction / jump redirect
ex_redirect_pc  in  32  redirect target
id_ready  in  1  ID accepts the output register this cycle
if_valid  out  1  output register holds an instruction
if_instr  out  32  instruction
if_pc  out  32  instruction PC
if_pred_taken  out  1  prediction applied (taken and hit)

Behaviour:
- Clock is clk; reset is reset_n, asynchronous, active-low.
- Reset values: instr_req=0, bht_rd_en=0, if_valid=0, if_instr=0, if_pc=0, if_pred_taken=0. Internal fetch_pc=BOOT_ADDR, state=BOOT, kill=0.
- At most one outstanding transaction.
- FSM:
  - BOOT: one cycle with no request. Goes to REQ.
  - REQ: instr_req=1, instr_addr=fetch_pc. On instr_gnt: bht_rd_en=1 and bht_pc=fetch_pc in the same cycle (combinational), then go to WAIT.
  - WAIT: in the first WAIT cycle, capture bht_predict_taken, btb_hit and {btb_target[31:2],2'b00} into pred regs. On instr_rvalid:
    - If the output register is free (!if_valid or id_ready): load it and go to REQ.
    - Otherwise: hold the response in pending regs and go to STALL.
  - STALL: when id_ready, move pending into the output register and go to REQ.
- Next PC, computed when the response is consumed:
  - taken = PRED_EN & pred_taken & pred_hit → next PC = pred target, if_pred_taken=1.
  - Otherwise next PC = PC+4, wrapping mod 2^32.
  - If rvalid arrives in the first WAIT cycle, the live bht/btb inputs are used (bypass) instead of the pred regs.
- Output register:
  - id_ready with if_valid and no new load: if_valid clears next cycle.
  - id_ready with a simultaneous load: the register is overwritten, no bubble.
- Redirect (ex_redirect=1) has highest priority:
  - The output register is cleared (if_valid=0) at the next edge.
  - fetch_pc becomes {ex_redirect_pc[31:2],2'b00}.
  - BOOT or REQ without gnt: go to (or stay in) REQ. instr_addr switches to the new PC the next cycle; the memory interface permits address change while gnt is low.
  - REQ with gnt in the same cycle: the accepted fetch is stale. Set kill and go to WAIT. The response is discarded, then go to REQ at the redirect PC; bht_rd_en is still pulsed for the stale fetch.
  - WAIT: set kill; on rvalid the response is dropped and the FSM goes to REQ. A redirect on the same cycle as rvalid drops that response and goes to REQ directly.
  - STALL: drop the pending entry and go to REQ.
- A redirect while kill is already set just updates fetch_pc.
- instr_rvalid outside WAIT is ignored.
- Reset mid-transaction returns everything to reset values; a late rvalid after reset is ignored (state BOOT/REQ).

Test Plan:
- Boot, gnt and rvalid the cycle after each request, id_ready=1, no hits → instr_addr sequence 0x0, 0x4, 0x8; if_pc matches; if_pred_taken=0; bht_pc=instr_addr on each gnt cycle.
- Fetch at 0x10 with bht_predict_taken=1, btb_hit=1, target 0x40, rvalid two cycles after gnt → if_pc=0x10 with if_pred_taken=1; next instr_addr=0x40.
- Same as above but rvalid the cycle after gnt (bypass path) → next instr_addr=0x40. With btb_hit=0 → 0x14.
- ex_redirect to 0x200 while WAIT for 0x8 → response for 0x8 is never presented; next request goes to 0x200; if_valid=0 in the cycle after the redirect.
- id_ready=0 for 3 cycles with if_valid=1, next response arrives → STALL; no new request. When id_ready=1, the pending instruction is presented next cycle and the request resumes.
- ex_redirect coincident with gnt at 0xC, target 0x300 → the 0xC response is discarded; the next accepted address is 0x300.
